// File: rtl/uart_ascii_tx_if.sv
// Symbol/handshake bundle between the report formatter and the UART ASCII transmitter.
// The formatter is the master (drives start/code); the transmitter is the slave.
interface uart_ascii_tx_if;
    logic       start;
    logic [4:0] code;
    logic       t;
    logic       r_next;

    modport master (output start, output code, input t, input r_next);
    modport slave  (input start, input code, output t, output r_next);
endinterface

// File: rtl/uart_ascii_tx.sv
// 8N1 LSB-first UART transmitter with a 5-bit symbol-to-ASCII coder in front of it.
// One frame per accepted start; r_next pulses for the single DONE cycle after the stop bit.
module uart_ascii_tx #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic            clk,
    input  logic            rst,
    uart_ascii_tx_if.slave  bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA,
        STOP_BIT,
        DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             t_q;
    logic             r_next_q;
    logic [7:0]       ascii_d;
    logic             baud_end;

    assign baud_end = (baud_q == CNT_W'(CLKS_PER_BIT - 1));

    // Digits, upper-case variables/error prefix, CR, '+', lower-case complemented variables.
    always_comb begin
        ascii_d = 8'h3F;
        case (bus.code) inside
            [5'd0:5'd9]:   ascii_d = 8'h30 + {3'b000, bus.code};
            [5'd10:5'd15]: ascii_d = 8'h37 + {3'b000, bus.code};
            5'd16:         ascii_d = 8'h0D;
            5'd17:         ascii_d = 8'h2B;
            [5'd26:5'd31]: ascii_d = 8'h47 + {3'b000, bus.code};
            default:       ascii_d = 8'h3F;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            t_q      <= 1'b1;
            r_next_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    t_q      <= 1'b1;
                    r_next_q <= 1'b0;
                    if (bus.start) begin
                        shift_q <= ascii_d;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        t_q     <= 1'b0;
                        state_q <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        t_q     <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        // The register shifts so the next data bit is always at index 1 here.
                        shift_q <= shift_q >> 1;
                        if (bit_q == 3'd7) begin
                            t_q     <= 1'b1;
                            state_q <= STOP_BIT;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            t_q   <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP_BIT: begin
                    if (baud_end) begin
                        baud_q   <= '0;
                        r_next_q <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DONE: begin
                    r_next_q <= 1'b0;
                    t_q      <= 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    t_q      <= 1'b1;
                    r_next_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.t      = t_q;
    assign bus.r_next = r_next_q;
endmodule

// File: tb/tb_uart_ascii_tx.sv
// Directed + randomized bench for uart_ascii_tx at CLKS_PER_BIT=4, checking the serial line
// cycle by cycle against a frame built from the symbol-to-ASCII table.
module tb_uart_ascii_tx;
    localparam int C = 4;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    uart_ascii_tx_if bus ();

    uart_ascii_tx #(.CLKS_PER_BIT(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ascii_of(input int c);
        if (c <= 9)       return 8'(48 + c);
        else if (c <= 15) return 8'(65 + (c - 10));
        else if (c == 16) return 8'h0D;
        else if (c == 17) return 8'h2B;
        else if (c >= 26) return 8'(97 + (c - 26));
        else              return 8'h3F;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Caller is positioned just after an edge with the DUT idle; the next edge latches the code.
    task automatic run_frame(input int c, input bit hold, input int c_next, input bit glitch);
        logic [7:0] b;
        logic [9:0] f;
        b = ascii_of(c);
        f = {1'b1, b, 1'b0};
        bus.start = 1'b1;
        bus.code  = 5'(c);
        tick();
        for (int k = 0; k < 10 * C; k++) begin
            chk($sformatf("t code=%0d k=%0d", c, k), bus.t, f[k / C]);
            chk($sformatf("r_next code=%0d k=%0d", c, k), bus.r_next, 1'b0);
            if (glitch && k >= 13 && k < 17) begin
                bus.start = 1'b1;
                bus.code  = 5'(c) ^ 5'h1F;
            end else begin
                bus.start = hold;
            end
            tick();
        end
        chk($sformatf("done t code=%0d", c), bus.t, 1'b1);
        chk($sformatf("done r_next code=%0d", c), bus.r_next, 1'b1);
        if (hold) bus.code = 5'(c_next);
        tick();
        chk($sformatf("post t code=%0d", c), bus.t, 1'b1);
        chk($sformatf("post r_next code=%0d", c), bus.r_next, 1'b0);
        $display("tx code=%0d byte=0x%02h hold=%0d glitch=%0d", c, b, hold, glitch);
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s t i=%0d", tag, i), bus.t, 1'b1);
            chk($sformatf("%s r_next i=%0d", tag, i), bus.r_next, 1'b0);
        end
    endtask

    initial begin
        int sweep [8];
        int rc;
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.code  = '0;

        // Reset state
        tick();
        tick();
        chk("reset t", bus.t, 1'b1);
        chk("reset r_next", bus.r_next, 1'b0);
        rst = 1'b0;
        tick();

        // Single 'A' frame
        run_frame(10, 1'b0, 0, 1'b0);

        // Coder sweep, then random codes
        sweep = '{0, 9, 15, 16, 17, 26, 31, 20};
        foreach (sweep[i]) run_frame(sweep[i], 1'b0, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rc = int'($urandom_range(31, 0));
            run_frame(rc, 1'b0, 0, 1'b0);
        end

        // Back-to-back with start held: "E", "1", CR
        run_frame(14, 1'b1, 1, 1'b0);
        run_frame(1, 1'b1, 16, 1'b0);
        run_frame(16, 1'b0, 0, 1'b0);

        // Start/code glitch mid-frame must be ignored; exactly one r_next
        rc = int'($urandom_range(31, 0));
        run_frame(rc, 1'b0, 0, 1'b1);
        idle_check("after glitch", 2 * C);

        // Reset during DATA bit 3 of 'A' (bit 3 = 0, so t must jump high)
        bus.start = 1'b1;
        bus.code  = 5'd10;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 4 * C + 1; k++) tick();
        chk("pre-reset t bit3", bus.t, 1'b0);
        rst = 1'b1;
        #1;
        chk("async reset t", bus.t, 1'b1);
        chk("async reset r_next", bus.r_next, 1'b0);
        idle_check("in reset", 2);
        rst = 1'b0;
        idle_check("after reset", 12 * C);
        rc = int'($urandom_range(31, 0));
        run_frame(rc, 1'b0, 0, 1'b0);

        // Long idle
        idle_check("idle", 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
